// File: rtl/alu_arb_pkg.sv
// Shared types for the ALU arbiter: op/state enums, response layout and index helper.
// alu_rsp_t describes the default 32-bit / 4-requester response as seen by external consumers.
package alu_arb_pkg;

  localparam int ALU_DATAW = 32;
  localparam int ALU_IDW   = 2;

  typedef enum logic {
    ALU_ADD = 1'b0,
    ALU_INC = 1'b1
  } alu_op_e;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [ALU_DATAW-1:0] data;
    logic                 p_flag;
    logic [ALU_IDW-1:0]   id;
  } alu_rsp_t;

  function automatic int unsigned wrap_inc(input int unsigned i, input int unsigned n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU: op ADD -> a+b, p_flag = sum!=0; op INC -> a+1, p_flag = a>b (unsigned).
// Zero latency, no flow control.
module alu
  import alu_arb_pkg::*;
#(
  parameter int DATAW = 32
) (
  input  logic [DATAW-1:0] a,
  input  logic [DATAW-1:0] b,
  input  alu_op_e          op,
  output logic [DATAW-1:0] alu_out,
  output logic             p_flag
);

  logic [DATAW-1:0] sum;

  assign sum = a + b;

  always_comb begin
    alu_out = sum;
    p_flag  = |sum;
    if (op == ALU_INC) begin
      alu_out = a + DATAW'(1);
      p_flag  = (a > b);
    end
  end

endmodule

// File: rtl/alu_arbiter_rr.sv
// Round-robin picker: first asserted req at or above ptr, wrapping; grant is one-hot and gated by en.
// Purely combinational; en=0 suppresses the grant but grant_idx still reports the candidate.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

  logic           found;
  logic [IDW-1:0] cand;

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    grant     = '0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = IDW'((32'(ptr) + 32'(i)) % 32'(NREQ));
      if (!found && req[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    if (en && found) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU among NREQ requesters; 1-cycle registered, ID-tagged response.
// A stalled response blocks all grants; optional lock mode under ALU_ARB_LOCK_EN.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter  int DATAW = 32,
  parameter  int NREQ  = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DATAW-1:0] req_a,
  input  logic [NREQ*DATAW-1:0] req_b,
  input  logic [NREQ-1:0]       req_op,
`ifdef ALU_ARB_LOCK_EN
  input  logic [NREQ-1:0]       req_lock,
  output logic [IDW-1:0]        lock_owner,
`endif
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  output logic [DATAW-1:0]      rsp_data,
  output logic                  rsp_p_flag,
  output logic [IDW-1:0]        rsp_id,
  input  logic                  rsp_ready
);

  typedef struct packed {
    logic [DATAW-1:0] data;
    logic             p_flag;
    logic [IDW-1:0]   id;
  } rsp_t;

  arb_state_e       state_q, state_d;
  logic [IDW-1:0]   rr_ptr, rr_ptr_d;
  logic [IDW-1:0]   grant_idx;
  logic [NREQ-1:0]  eligible, grant;
  logic             can_issue, xfer;
  logic [DATAW-1:0] alu_a, alu_b, alu_out;
  alu_op_e          alu_op;
  logic             alu_p_flag;
  logic             rsp_vld_q;
  rsp_t             rsp_q;

  assign can_issue = !rsp_vld_q || rsp_ready;

`ifdef ALU_ARB_LOCK_EN
  logic [IDW-1:0] owner_q, owner_d;

  always_comb begin
    eligible = req_valid;
    if (state_q == LOCKED) eligible = req_valid & (NREQ'(1) << owner_q);
  end

  assign lock_owner = owner_q;
`else
  assign eligible = req_valid;
`endif

  // Reset gating keeps a request from being accepted while the pipeline is being cleared.
  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req       (eligible),
    .ptr       (rr_ptr),
    .en        (can_issue && rst_n),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;
  assign xfer      = |grant;

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = ALU_ADD;
    if (xfer) begin
      alu_a  = req_a[grant_idx*DATAW +: DATAW];
      alu_b  = req_b[grant_idx*DATAW +: DATAW];
      alu_op = alu_op_e'(req_op[grant_idx]);
    end
  end

  alu #(.DATAW(DATAW)) u_alu (
    .a       (alu_a),
    .b       (alu_b),
    .op      (alu_op),
    .alu_out (alu_out),
    .p_flag  (alu_p_flag)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr;
`ifdef ALU_ARB_LOCK_EN
    owner_d  = owner_q;
    if (xfer) begin
      // A locked transfer keeps the pointer parked so the owner resumes its normal slot afterwards.
      if (req_lock[grant_idx]) begin
        state_d = LOCKED;
        owner_d = grant_idx;
      end else begin
        state_d  = ARB;
        rr_ptr_d = IDW'(wrap_inc(32'(grant_idx), NREQ));
      end
    end
`else
    if (xfer) rr_ptr_d = IDW'(wrap_inc(32'(grant_idx), NREQ));
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ARB;
      rr_ptr  <= '0;
`ifdef ALU_ARB_LOCK_EN
      owner_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      rr_ptr  <= rr_ptr_d;
`ifdef ALU_ARB_LOCK_EN
      owner_q <= owner_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_vld_q <= 1'b0;
      rsp_q     <= '0;
    end else if (xfer) begin
      rsp_vld_q    <= 1'b1;
      rsp_q.data   <= alu_out;
      rsp_q.p_flag <= alu_p_flag;
      rsp_q.id     <= grant_idx;
    end else if (rsp_ready) begin
      rsp_vld_q <= 1'b0;
    end
  end

  assign rsp_valid  = rsp_vld_q;
  assign rsp_data   = rsp_q.data;
  assign rsp_p_flag = rsp_q.p_flag;
  assign rsp_id     = rsp_q.id;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: expected responses queued at grant time, checked when drained.
// Lock-mode steps are compiled only when ALU_ARB_LOCK_EN is defined.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [127:0] req_a, req_b;
  logic [3:0]   req_op;
  logic [3:0]   req_ready;
  logic         rsp_valid;
  logic [31:0]  rsp_data;
  logic         rsp_p_flag;
  logic [1:0]   rsp_id;
  logic         rsp_ready;
`ifdef ALU_ARB_LOCK_EN
  logic [3:0]   req_lock;
  logic [1:0]   lock_owner;
`endif

  int n_cmp = 0;
  int n_err = 0;
  alu_rsp_t sb[$];
  alu_rsp_t mon_obs, mon_exp, dropped;
  logic [31:0] op_a [4];
  logic [31:0] op_b [4];
  logic        op_o [4];

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
`ifdef ALU_ARB_LOCK_EN
    .req_lock   (req_lock),
    .lock_owner (lock_owner),
`endif
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_p_flag (rsp_p_flag),
    .rsp_id     (rsp_id),
    .rsp_ready  (rsp_ready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic alu_rsp_t ref_rsp(input logic [31:0] a, input logic [31:0] b,
                                       input logic op, input int id);
    alu_rsp_t r;
    r.id = 2'(id);
    if (op) begin
      r.data   = a + 32'd1;
      r.p_flag = (a > b);
    end else begin
      r.data   = a + b;
      r.p_flag = (r.data != 32'd0);
    end
    return r;
  endfunction

  task automatic put(input int i, input logic [31:0] a, input logic [31:0] b, input logic op);
    op_a[i] = a;
    op_b[i] = b;
    op_o[i] = op;
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_op[i] = op;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_grant(input string tag, input int g);
    check(tag, 64'(req_ready), 64'(4'b0001 << g));
    sb.push_back(ref_rsp(op_a[g], op_b[g], op_o[g], g));
  endtask

  // Drain-side scoreboard: a response is consumed on any cycle where valid and ready meet.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      check("sb_nonempty", 64'(sb.size() != 0), 64'(1));
      if (sb.size() != 0) begin
        mon_exp        = sb.pop_front();
        mon_obs.data   = rsp_data;
        mon_obs.p_flag = rsp_p_flag;
        mon_obs.id     = rsp_id;
        check("rsp", 64'(mon_obs), 64'(mon_exp));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
`ifdef ALU_ARB_LOCK_EN
    req_lock  = '0;
`endif
    for (int i = 0; i < 4; i++) put(i, 32'd0, 32'd0, 1'b0);
    repeat (2) tick();

    // Request presented during reset must not be accepted.
    put(0, 32'd1, 32'd1, 1'b0);
    req_valid = 4'b0001;
    #1;
    check("rst_ready", 64'(req_ready), 64'(0));
    tick();
    check("rst_valid", 64'(rsp_valid), 64'(0));
    check("rst_data", 64'(rsp_data), 64'(0));
    check("rst_pflag", 64'(rsp_p_flag), 64'(0));
    check("rst_id", 64'(rsp_id), 64'(0));
    req_valid = '0;
    rst_n     = 1'b1;

    repeat (5) begin
      tick();
      check("idle_valid", 64'(rsp_valid), 64'(0));
      check("idle_ready", 64'(req_ready), 64'(0));
    end

    // Single requester: basic add and wrap-around add.
    put(0, 32'd5, 32'd7, 1'b0);
    req_valid = 4'b0001;
    #1;
    expect_grant("single_add", 0);
    tick();
    check("lat1_valid", 64'(rsp_valid), 64'(1));
    put(0, 32'hFFFF_FFFF, 32'd1, 1'b0);
    #1;
    expect_grant("wrap_add", 0);
    tick();
    req_valid = '0;
    check("lat1_valid2", 64'(rsp_valid), 64'(1));
    tick();
    check("drained", 64'(rsp_valid), 64'(0));

    // All valid: pointer is 1 after the previous grant to requester 0.
    put(0, 32'd100, 32'd200, 1'b0);
    put(1, 32'hFFFF_FFFF, 32'd0, 1'b1);
    put(2, 32'd9, 32'd3, 1'b1);
    put(3, 32'd0, 32'd0, 1'b0);
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      expect_grant("rr_order", (1 + k) % 4);
      tick();
    end
    req_valid = '0;

    // Backpressure: response stalls, grants blocked, then release issues in the same cycle.
    put(3, 32'd3, 32'd4, 1'b0);
    req_valid = 4'b1000;
    #1;
    expect_grant("bp_first", 3);
    tick();
    put(0, 32'd20, 32'd22, 1'b0);
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_ready", 64'(req_ready), 64'(0));
      check("bp_valid", 64'(rsp_valid), 64'(1));
      check("bp_data", 64'(rsp_data), 64'(7));
      check("bp_id", 64'(rsp_id), 64'(3));
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    expect_grant("bp_release", 0);
    tick();
    req_valid = '0;
    check("bp_stay", 64'(rsp_valid), 64'(1));

    // Reset while a response is pending and stalled.
    put(2, 32'd1, 32'd1, 1'b0);
    req_valid = 4'b0100;
    #1;
    expect_grant("pre_rst", 2);
    tick();
    req_valid = '0;
    rsp_ready = 1'b0;
    #1;
    check("pend_valid", 64'(rsp_valid), 64'(1));
    rst_n   = 1'b0;
    dropped = sb.pop_back();
    tick();
    check("rst_mid_valid", 64'(rsp_valid), 64'(0));
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    put(1, 32'd7, 32'd8, 1'b0);
    put(3, 32'd10, 32'd20, 1'b1);
    req_valid = 4'b1111;
    #1;
    expect_grant("rst_ptr0", 0);
    tick();
    req_valid = '0;

`ifdef ALU_ARB_LOCK_EN
    // Pointer is 1: requester 1 locks for three ops, releases on the fourth.
    put(0, 32'd2, 32'd2, 1'b0);
    put(3, 32'd6, 32'd1, 1'b1);
    req_valid = 4'b1011;
    req_lock  = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      put(1, 32'd50 + 32'(k), 32'd0, 1'b1);
      #1;
      expect_grant("lock_hold", 1);
      tick();
      check("lock_owner", 64'(lock_owner), 64'(1));
    end
    req_lock = '0;
    put(1, 32'd60, 32'd61, 1'b0);
    #1;
    expect_grant("lock_last", 1);
    tick();
    req_valid = 4'b1001;
    #1;
    expect_grant("lock_after", 3);
    tick();
    #1;
    expect_grant("lock_wrap", 0);
    tick();
    req_valid = '0;
`endif

    repeat (2) tick();
    check("sb_drained", 64'(sb.size()), 64'(0));
    check("final_idle", 64'(rsp_valid), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
